// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution stage that consumes decoder alu_control and
// regwrite_control. It accepts one R-type operation through a valid/ready
// handshake and presents the result to write-back through a second valid/ready
// handshake.
//
// Timing:
//   - AND, OR, ADD, SUB, SLL, SRL and XOR complete in one cycle.
//   - MUL uses an iterative shift-add loop. It takes WIDTH iterations, so the
//     latency is WIDTH+1.
//
// Optional build macro MUL_EARLY_EXIT_EN:
//   - MUL stops as soon as the remaining multiplier bits are zero.
//   - A MUL with op_b == 0 completes in one cycle.
//   - Result values are the same in both builds. Only the latency changes.
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_control,
    input  logic              regwrite_control,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data,
    output logic              illegal_op,
    output logic              busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [WIDTH-1:0]  r_acc;
    logic [CW-1:0]     r_count;

    logic              r_wb_en;
    logic [REG_AW-1:0] r_wb_addr;
    logic [WIDTH-1:0]  r_wb_data;
    logic              r_illegal;

    logic              w_accept;
    logic              w_is_mul;
    logic              w_legal;
    logic              w_mul_skip;
    logic              w_start_mul;
    logic [SHW-1:0]    w_shamt;
    logic [WIDTH-1:0]  w_result;
    logic [WIDTH-1:0]  w_acc_nxt;
    logic [WIDTH-1:0]  w_mcand_nxt;
    logic [WIDTH-1:0]  w_mplier_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic              w_mul_done;

    assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && wb_ready);
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (alu_control == OP_MUL);
    assign w_legal  = ~alu_control[3];
    assign w_shamt  = op_b[SHW-1:0];

`ifdef MUL_EARLY_EXIT_EN
    // A zero multiplier produces a zero product, so the loop is skipped.
    assign w_mul_skip = (op_b == '0);
`else
    assign w_mul_skip = 1'b0;
`endif

    assign w_start_mul = w_accept && w_is_mul && !w_mul_skip;

    // One shift-add step. The final step is folded into the cycle that moves
    // the FSM to DONE, so the loop keeps busy high for WIDTH cycles.
    assign w_acc_nxt    = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mcand_nxt  = r_mcand << 1;
    assign w_mplier_nxt = r_mplier >> 1;
    assign w_count_nxt  = r_count + CW'(1);

`ifdef MUL_EARLY_EXIT_EN
    assign w_mul_done = (w_count_nxt == ITER_LAST) || (w_mplier_nxt == '0);
`else
    assign w_mul_done = (w_count_nxt == ITER_LAST);
`endif

    // Single-cycle datapath. Illegal codes produce 0, and so does a skipped MUL.
    always_comb begin
        w_result = '0;
        case (alu_control)
            OP_AND:  w_result = op_a & op_b;
            OP_OR:   w_result = op_a | op_b;
            OP_ADD:  w_result = op_a + op_b;
            OP_SLL:  w_result = op_a << w_shamt;
            OP_SUB:  w_result = op_a - op_b;
            OP_SRL:  w_result = op_a >> w_shamt;
            OP_MUL:  w_result = '0;
            OP_XOR:  w_result = op_a ^ op_b;
            default: w_result = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic. An accept in DONE retires the current result and
    // starts the new operation exactly as it would start from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)
                    w_state_nxt = w_start_mul ? S_MUL : S_DONE;
                else if ((r_state == S_DONE) && wb_ready)
                    w_state_nxt = S_IDLE;
            end
            S_MUL: begin
                if (w_mul_done) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Multiplier operands, accumulator and iteration count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_start_mul) begin
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (r_state == S_MUL) begin
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Write-back registers. Address, enable and illegal flag are captured at
    // accept. Data is captured at accept for single-cycle ops and at loop end
    // for MUL. Nothing changes while DONE waits for wb_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_wb_en   <= regwrite_control && w_legal && (rd_addr != '0);
            r_wb_addr <= rd_addr;
            r_illegal <= !w_legal;
            if (!w_start_mul) r_wb_data <= w_result;
        end else if ((r_state == S_MUL) && w_mul_done) begin
            r_wb_data <= w_acc_nxt;
        end
    end

    assign wb_valid   = (r_state == S_DONE);
    assign busy       = (r_state == S_MUL);
    assign wb_en      = r_wb_en;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit. Issued operations push their expected result
// into a queue. A monitor pops the queue at each write-back handshake and
// checks data, enable, address, illegal flag and first-valid latency.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic        regwrite_control;
    logic [4:0]  rd_addr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal_op;
    logic        busy;

`ifdef MUL_EARLY_EXIT_EN
    localparam int LAT_MUL16 = 6;
    localparam int LAT_MUL0  = 1;
`else
    localparam int LAT_MUL16 = 33;
    localparam int LAT_MUL0  = 33;
`endif

    alu_exec_unit #(.WIDTH(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .regwrite_control(regwrite_control),
        .rd_addr(rd_addr), .op_a(op_a), .op_b(op_b), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        en;
        logic        ill;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   seen = 1'b0;
    int   first_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: records the first cycle of each result and checks at retire.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (wb_valid) begin
            if (!seen) begin
                seen = 1'b1;
                first_cyc = cyc;
            end
            if (wb_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wb", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wb_data", 64'(wb_data), 64'(e.data));
                    chk("wb_addr", 64'(wb_addr), 64'(e.addr));
                    chk("wb_en", 64'(wb_en), 64'(e.en));
                    chk("illegal_op", 64'(illegal_op), 64'(e.ill));
                    chk("latency", 64'(first_cyc - e.acc_cyc + 1), 64'(e.lat));
                end
                seen = 1'b0;
            end
        end
    end

    // Drives one operation and waits, bounded, for it to be accepted.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we, input logic [31:0] ed,
                         input logic een, input logic eil, input int lat);
        bit ok = 1'b0;
        exp_t e;
        in_valid = 1'b1; alu_control = op; op_a = a; op_b = b;
        rd_addr = rd; regwrite_control = we;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk); #1;
            e.addr = rd; e.data = ed; e.en = een; e.ill = eil; e.lat = lat; e.acc_cyc = cyc;
            sb.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_control = '0; regwrite_control = 1'b0;
        rd_addr = '0; op_a = '0; op_b = '0; wb_ready = 1'b1;
        #3;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_illegal", 64'(illegal_op), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wb_addr", 64'(wb_addr), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // ADD basic
        issue(4'b0010, 32'd5, 32'd7, 5'd3, 1'b1, 32'd12, 1'b1, 1'b0, 1);
        drain();

        // SUB with write-back stalled for 4 cycles
        wb_ready = 1'b0;
        issue(4'b0100, 32'd3, 32'd5, 5'd4, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(wb_valid), 64'd1);
            chk("stall_data", 64'(wb_data), 64'hFFFF_FFFE);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1; wb_ready = 1'b1;
        drain();

        // MUL
        issue(4'b0110, 32'h1234, 32'h10, 5'd5, 1'b1, 32'h0001_2340, 1'b1, 1'b0, LAT_MUL16);
        @(negedge clk);
        chk("mul_busy", 64'(busy), 64'd1);
        chk("mul_in_ready", 64'(in_ready), 64'd0);
        drain();

        // SLL (upper shift-amount bits ignored), then illegal code
        issue(4'b0011, 32'd1, 32'h25, 5'd6, 1'b1, 32'h20, 1'b1, 1'b0, 1);
        issue(4'b1010, 32'h55, 32'h66, 5'd7, 1'b1, 32'd0, 1'b0, 1'b1, 1);
        drain();

        // Logic, SRL, wrapping MUL, zero MUL, regwrite off
        issue(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd10, 1'b1, 32'h0F00_0F00, 1'b1, 1'b0, 1);
        issue(4'b0001, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd11, 1'b1, 32'hFFF0_FFF0, 1'b1, 1'b0, 1);
        issue(4'b0101, 32'h8000_0000, 32'h3F, 5'd12, 1'b1, 32'd1, 1'b1, 1'b0, 1);
        issue(4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'd1, 1'b1, 1'b0, 33);
        issue(4'b0110, 32'hDEAD_BEEF, 32'd0, 5'd14, 1'b1, 32'd0, 1'b1, 1'b0, LAT_MUL0);
        issue(4'b0111, 32'h1, 32'h3, 5'd15, 1'b0, 32'h2, 1'b0, 1'b0, 1);
        drain();

        // Back-to-back: ADD accepted on the cycle the XOR retires
        issue(4'b0111, 32'h0000_F0F0, 32'h0000_0FF0, 5'd8, 1'b1, 32'h0000_FF00, 1'b1, 1'b0, 1);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd2, 5'd9, 1'b1, 32'd1, 1'b1, 1'b0, 1);
        drain();

        // Write to x0: handshake completes, enable suppressed
        issue(4'b0010, 32'd5, 32'd7, 5'd0, 1'b1, 32'd12, 1'b0, 1'b0, 1);
        drain();

        // Reset in the middle of a MUL
        issue(4'b0110, 32'h1234, 32'hFFFF, 5'd16, 1'b1, 32'd0, 1'b1, 1'b0, 33);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_wb_valid", 64'(wb_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_wb_data", 64'(wb_data), 64'd0);
        chk("midrst_wb_addr", 64'(wb_addr), 64'd0);
        chk("midrst_wb_en", 64'(wb_en), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        issue(4'b0010, 32'h10, 32'h20, 5'd31, 1'b1, 32'h30, 1'b1, 1'b0, 1);
        drain();

        chk("pending_results", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
